sdram_port_arbiter: RTL
=======================

// Module: sdram_port_arbiter
// PURPOSE
//  Shares the single SDRAM controller command port between two requesters: ch0 (video fetch) and ch1 (bridge dataslot loader).
//  Sits between the requesters and the SDRAM controller inside Main, in the sys_clock domain.
//  Fixed priority to ch0, with a starvation limit for ch1.
//  Routes in-order read data back to the issuing channel using a tag FIFO of outstanding reads.
// PARAMETERS
//  ADDR_WIDTH    25  word address width (32M x16 SDRAM)
//  DATA_WIDTH    16  data width
//  TAG_DEPTH     4   max outstanding reads; power of 2, >=2
//  STARVE_LIMIT  8   consecutive ch0 grants with ch1 pending before ch1 is forced
// PORTS
//  clock        in   1   system clock; single clock domain
//  reset        in   1   asynchronous, active-high
//  chN_req      in   1   N=0,1; request, held with addr/we/wdata stable until chN_ack
//  chN_we       in   1   1=write, 0=read
//  chN_addr     in   ADDR_WIDTH  word address
//  chN_wdata    in   DATA_WIDTH  write data
//  chN_ack      out  1   one-cycle pulse: request accepted by controller
//  chN_rvalid   out  1   one-cycle pulse: chN_rdata valid
//  chN_rdata    out  DATA_WIDTH  read data
//  mem_req      out  1   command to controller, held until mem_ack
//  mem_we       out  1
//  mem_addr     out  ADDR_WIDTH
//  mem_wdata    out  DATA_WIDTH
//  mem_ack      in   1   controller accepted command (one cycle)
//  mem_rvalid   in   1   read data return, in issue order
//  mem_rdata    in   DATA_WIDTH
//  err_orphan   out  1   sticky: mem_rvalid received with tag FIFO empty
// BEHAVIOUR
//  Reset values:
//   - all outputs 0, state IDLE, tag FIFO empty, starve count 0
//   - outputs held at these values while reset is high
//  States:
//   - IDLE: pick owner from chN_req.
//     - only one channel requesting -> that channel
//     - both requesting -> ch0, unless starve==STARVE_LIMIT -> ch1
//     - go to BUSY0/BUSY1 and register mem_* from the owner
//   - BUSYn: mem_req=1, mem_* stable
//     - on mem_ack: chn_ack=1 in the same cycle (comb from mem_ack)
//     - if !we, push tag n
//     - go to IDLE next cycle
//  Timing:
//   - Latency: req seen in IDLE at cycle T -> mem_req=1 at T+1
//   - Back-to-back commands are spaced >=2 cycles (ack at M, next mem_req at M+2)
//  Read blocking:
//   - A read is not granted from IDLE while the FIFO is full; a write from either channel may still be granted.
//   - With both channels reading, FIFO full -> stay IDLE.
//  Starve counter:
//   - +1 on each ch0 grant while ch1_req=1, saturating at STARVE_LIMIT
//   - cleared on any ch1 grant, or when ch1_req=0
//  Read return:
//   - on mem_rvalid, pop tag t; cht_rvalid=1 and cht_rdata=mem_rdata in the same cycle
//   - other channel's rvalid=0; rdata is a don't-care when rvalid=0
//  Simultaneous push (read ack) and pop (rvalid) in the same cycle:
//   - both take effect; count unchanged
//   - data is popped from the old head, so full is legal to ack
//  Orphan return:
//   - mem_rvalid with FIFO empty -> no chN_rvalid, err_orphan=1 until reset
//  Requester withdraws req while in BUSYn:
//   - not legal; the command completes regardless
//  Reset mid-operation:
//   - everything cleared immediately (async)
//   - pending command dropped, outstanding tags lost
//   - later returns raise err_orphan
// STRUCTURE
//  Shared package sdram_arb_pkg:
//   - state enum {IDLE, BUSY0, BUSY1}
//   - tag type (1 bit channel id)
//   - default widths
//  Sub-module sdram_tag_fifo:
//   - TAG_DEPTH x 1-bit synchronous FIFO
//   - push/pop/full/empty/head
//   - async active-high reset
//   - simultaneous push+pop is legal when full
//  Top: arbitration FSM, starve counter, output muxing.
// TESTING
//  1. ch0 read only, addr 0x000100: mem_req at T+1, ack at T+3 -> ch0_ack at T+3; rvalid rdata=0xBEEF -> ch0_rvalid, ch0_rdata=0xBEEF
//  2. ch0 and ch1 both held continuously -> 8 ch0 grants, then 1 ch1 grant, then ch0 again; starve count returns to 0
//  3. 4 ch0 reads acked with no returns, then a 5th read request -> no mem_req until one mem_rvalid; then granted
//  4. ch1 read, then ch0 read; returns 0x1111, 0x2222 -> ch1_rvalid with 0x1111, then ch0_rvalid with 0x2222
//  5. FIFO full; mem_ack of a ch1 write while mem_rvalid arrives -> ch1_ack=1, correct read routed, count 3
//  6. mem_rvalid with FIFO empty -> no chN_rvalid, err_orphan=1; assert reset mid-BUSY0 -> mem_req=0 and err_orphan=0 immediately

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and default sizes for the SDRAM command-port arbiter.
// The tag records which channel issued each outstanding read.
package sdram_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_e;

    typedef logic tag_t;

    localparam tag_t TAG_CH0 = 1'b0;
    localparam tag_t TAG_CH1 = 1'b1;

    localparam int unsigned DEF_ADDR_WIDTH   = 25;
    localparam int unsigned DEF_DATA_WIDTH   = 16;
    localparam int unsigned DEF_TAG_DEPTH    = 4;
    localparam int unsigned DEF_STARVE_LIMIT = 8;

endpackage

// File: rtl/sdram_tag_fifo.sv
// Small FIFO of read tags, in controller issue order.
// Push and pop in the same cycle are both honoured, including when full.
module sdram_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_TAG_DEPTH
) (
    input  logic clock,
    input  logic reset,
    input  logic push_i,
    input  tag_t tag_i,
    input  logic pop_i,
    output tag_t head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q, count_d;
    tag_t          mem_q [DEPTH];
    logic          do_push, do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees the head slot this cycle, so a push into a full FIFO is safe.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= tag_i;
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-channel arbiter for the SDRAM controller command port: fixed priority to ch0
// with a starvation escape for ch1, and in-order routing of read returns by tag.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned TAG_DEPTH    = DEF_TAG_DEPTH,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ch0_req,
    input  logic                  ch0_we,
    input  logic [ADDR_WIDTH-1:0] ch0_addr,
    input  logic [DATA_WIDTH-1:0] ch0_wdata,
    output logic                  ch0_ack,
    output logic                  ch0_rvalid,
    output logic [DATA_WIDTH-1:0] ch0_rdata,
    input  logic                  ch1_req,
    input  logic                  ch1_we,
    input  logic [ADDR_WIDTH-1:0] ch1_addr,
    input  logic [DATA_WIDTH-1:0] ch1_wdata,
    output logic                  ch1_ack,
    output logic                  ch1_rvalid,
    output logic [DATA_WIDTH-1:0] ch1_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  err_orphan
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    state_e                state_q;
    logic                  mem_req_q, mem_we_q, err_orphan_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [SW-1:0]         starve_q, starve_d;

    logic ok0, ok1, grant0, grant1, starved;
    logic fifo_push, fifo_pop, fifo_full, fifo_empty;
    tag_t fifo_head;

    // Reads need a free tag slot; writes never do.
    assign ok0     = ch0_req && (ch0_we || !fifo_full);
    assign ok1     = ch1_req && (ch1_we || !fifo_full);
    assign starved = (starve_q == SW'(STARVE_LIMIT));
    assign grant1  = (state_q == IDLE) && ok1 && (!ok0 || starved);
    assign grant0  = (state_q == IDLE) && ok0 && !grant1;

    always_comb begin
        starve_d = starve_q;
        if (!ch1_req || grant1)
            starve_d = '0;
        else if (grant0 && !starved)
            starve_d = starve_q + 1'b1;
    end

    assign ch0_ack   = mem_ack && (state_q == BUSY0);
    assign ch1_ack   = mem_ack && (state_q == BUSY1);
    assign fifo_push = (ch0_ack || ch1_ack) && !mem_we_q;
    assign fifo_pop  = mem_rvalid && !fifo_empty;

    assign ch0_rvalid = fifo_pop && (fifo_head == TAG_CH0);
    assign ch1_rvalid = fifo_pop && (fifo_head == TAG_CH1);
    assign ch0_rdata  = ch0_rvalid ? mem_rdata : '0;
    assign ch1_rdata  = ch1_rvalid ? mem_rdata : '0;

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign err_orphan = err_orphan_q;

    sdram_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (fifo_push),
        .tag_i   ((state_q == BUSY1) ? TAG_CH1 : TAG_CH0),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            starve_q     <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            starve_q <= starve_d;
            if (mem_rvalid && fifo_empty) err_orphan_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (grant0) begin
                        state_q     <= BUSY0;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= ch0_we;
                        mem_addr_q  <= ch0_addr;
                        mem_wdata_q <= ch0_wdata;
                    end else if (grant1) begin
                        state_q     <= BUSY1;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= ch1_we;
                        mem_addr_q  <= ch1_addr;
                        mem_wdata_q <= ch1_wdata;
                    end
                end
                BUSY0, BUSY1: begin
                    if (mem_ack) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
